// File: rtl/mc_sequencer.sv
// Main control FSM of the multi-cycle MIPS core: phase sequencing, datapath
// strobes and the PC next-address selection.
module mc_sequencer #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode,
  input  logic              zero,
  input  logic [ADDR_W-1:0] imm,
  input  logic [ADDR_W-1:0] jtarget,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] next_addr,
  output logic              pc_write,
  output logic              ir_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              alu_src,
  output logic [1:0]        alu_op,
  output logic              halted,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ADDR    = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_EXEC_BR = 4'd7,
    S_WB_R    = 4'd8,
    S_WB_I    = 4'd9,
    S_WB_MEM  = 4'd10,
    S_HALT    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t cur_state;

  // State register; codes 12-15 fall back to FETCH through the default arm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S_FETCH;
    end else begin
      case (cur_state)
        S_FETCH:   cur_state <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:      cur_state <= S_EXEC_R;
            OP_ADDI:       cur_state <= S_EXEC_I;
            OP_LW, OP_SW:  cur_state <= S_ADDR;
            OP_BEQ:        cur_state <= S_EXEC_BR;
            OP_HALT:       cur_state <= S_HALT;
            default:       cur_state <= S_FETCH;
          endcase
        end
        S_EXEC_R:  cur_state <= S_WB_R;
        S_EXEC_I:  cur_state <= S_WB_I;
        S_ADDR:    cur_state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:  cur_state <= mem_ready ? S_WB_MEM : S_MEM_RD;
        S_MEM_WR:  cur_state <= mem_ready ? S_FETCH : S_MEM_WR;
        S_EXEC_BR: cur_state <= S_FETCH;
        S_WB_R:    cur_state <= S_FETCH;
        S_WB_I:    cur_state <= S_FETCH;
        S_WB_MEM:  cur_state <= S_FETCH;
        S_HALT:    cur_state <= S_HALT;
        default:   cur_state <= S_FETCH;
      endcase
    end
  end

  assign state = cur_state;

  // Strobe decode; gated by rst so a reset mid-access drops requests at once.
  always_comb begin
    next_addr  = pc_addr;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    halted     = 1'b0;
    if (rst) begin
      next_addr = '0;
    end else begin
      case (cur_state)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            next_addr = pc_addr + ADDR_ONE;
          end else begin
            next_addr = pc_addr;
          end
        end
        S_DECODE: begin
          if (opcode == OP_J) begin
            pc_write  = 1'b1;
            next_addr = jtarget;
          end else begin
            next_addr = pc_addr;
          end
        end
        S_EXEC_R: alu_op = 2'b10;
        S_EXEC_I, S_ADDR: begin
          alu_src = 1'b1;
          alu_op  = 2'b00;
        end
        S_MEM_RD: mem_read = 1'b1;
        S_MEM_WR: mem_write = 1'b1;
        S_EXEC_BR: begin
          alu_op = 2'b01;
          // pc_addr already points past the beq, so the offset applies directly.
          if (zero) begin
            pc_write  = 1'b1;
            next_addr = pc_addr + imm;
          end else begin
            next_addr = pc_addr;
          end
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_WB_I: reg_write = 1'b1;
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: next_addr = pc_addr;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: a per-cycle vector table walking several
// instructions from reset, plus halt-hold and reset-abort sequences.
module tb_mc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, imm, jtarget, pc_addr, next_addr;
  logic       zero, mem_ready;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst;
  logic       mem_to_reg, alu_src, halted;
  logic [1:0] alu_op;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  mc_sequencer #(.ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .imm(imm),
    .jtarget(jtarget), .pc_addr(pc_addr), .mem_ready(mem_ready),
    .next_addr(next_addr), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .alu_op(alu_op), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  // Strobe bundle: pcw irw mr mw rw rd m2r as aop[1:0] h
  logic [10:0] sb;
  assign sb = {pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst,
               mem_to_reg, alu_src, alu_op, halted};

  localparam logic [10:0] S_NONE = 11'b00000000000;
  localparam logic [10:0] S_FRDY = 11'b11100000000;
  localparam logic [10:0] S_MRD  = 11'b00100000000;
  localparam logic [10:0] S_EXR  = 11'b00000000100;
  localparam logic [10:0] S_WBR  = 11'b00001100000;
  localparam logic [10:0] S_IMM  = 11'b00000001000;
  localparam logic [10:0] S_WBI  = 11'b00001000000;
  localparam logic [10:0] S_MWR  = 11'b00010000000;
  localparam logic [10:0] S_WBM  = 11'b00001010000;
  localparam logic [10:0] S_BRN  = 11'b00000000010;
  localparam logic [10:0] S_BRT  = 11'b10000000010;
  localparam logic [10:0] S_JMP  = 11'b10000000000;
  localparam logic [10:0] S_HLT  = 11'b00000000001;

  localparam logic [5:0] RT = 6'b000000, AI = 6'b001000, LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011, BQ = 6'b000100, JJ = 6'b000010;
  localparam logic [5:0] HL = 6'b111111, NP = 6'b010101;

  typedef struct {
    logic [5:0]  op;
    logic        zr;
    logic        rdy;
    logic [5:0]  pc;
    logic [5:0]  im;
    logic [5:0]  jt;
    logic [3:0]  st;
    logic [5:0]  na;
    logic [10:0] sb;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, step, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic zr, input logic rdy,
                     input logic [5:0] pc, input logic [3:0] st,
                     input logic [5:0] na, input logic [10:0] s);
    vecs.push_back('{op: op, zr: zr, rdy: rdy, pc: pc, im: 6'b111010,
                     jt: 6'd42, st: st, na: na, sb: s});
  endtask

  initial begin
    // R-type from reset: the PC takes 1 on the first edge.
    add(RT, 1'b0, 1'b1, 6'd0,  4'd0,  6'd1,  S_FRDY);
    add(RT, 1'b0, 1'b1, 6'd1,  4'd1,  6'd1,  S_NONE);
    add(RT, 1'b0, 1'b1, 6'd1,  4'd2,  6'd1,  S_EXR);
    add(RT, 1'b0, 1'b1, 6'd1,  4'd8,  6'd1,  S_WBR);
    // addi
    add(AI, 1'b0, 1'b1, 6'd1,  4'd0,  6'd2,  S_FRDY);
    add(AI, 1'b0, 1'b1, 6'd2,  4'd1,  6'd2,  S_NONE);
    add(AI, 1'b0, 1'b1, 6'd2,  4'd3,  6'd2,  S_IMM);
    add(AI, 1'b0, 1'b1, 6'd2,  4'd9,  6'd2,  S_WBI);
    // sw
    add(SW, 1'b0, 1'b1, 6'd2,  4'd0,  6'd3,  S_FRDY);
    add(SW, 1'b0, 1'b1, 6'd3,  4'd1,  6'd3,  S_NONE);
    add(SW, 1'b0, 1'b1, 6'd3,  4'd4,  6'd3,  S_IMM);
    add(SW, 1'b0, 1'b1, 6'd3,  4'd6,  6'd3,  S_MWR);
    // beq not taken, with one fetch wait cycle
    add(BQ, 1'b0, 1'b0, 6'd3,  4'd0,  6'd3,  S_MRD);
    add(BQ, 1'b0, 1'b1, 6'd3,  4'd0,  6'd4,  S_FRDY);
    add(BQ, 1'b0, 1'b1, 6'd4,  4'd1,  6'd4,  S_NONE);
    add(BQ, 1'b0, 1'b1, 6'd4,  4'd7,  6'd4,  S_BRN);
    // beq taken: 5 + (-6) wraps to 63
    add(BQ, 1'b1, 1'b1, 6'd4,  4'd0,  6'd5,  S_FRDY);
    add(BQ, 1'b1, 1'b1, 6'd5,  4'd1,  6'd5,  S_NONE);
    add(BQ, 1'b1, 1'b1, 6'd5,  4'd7,  6'd63, S_BRT);
    // j, fetch increment wraps 63 -> 0
    add(JJ, 1'b0, 1'b1, 6'd63, 4'd0,  6'd0,  S_FRDY);
    add(JJ, 1'b0, 1'b1, 6'd0,  4'd1,  6'd42, S_JMP);
    // illegal opcode behaves as NOP
    add(NP, 1'b0, 1'b1, 6'd42, 4'd0,  6'd43, S_FRDY);
    add(NP, 1'b0, 1'b1, 6'd43, 4'd1,  6'd43, S_NONE);
    // lw with two memory wait cycles; mem_ready low in ADDR is ignored
    add(LW, 1'b0, 1'b1, 6'd43, 4'd0,  6'd44, S_FRDY);
    add(LW, 1'b0, 1'b1, 6'd44, 4'd1,  6'd44, S_NONE);
    add(LW, 1'b0, 1'b0, 6'd44, 4'd4,  6'd44, S_IMM);
    add(LW, 1'b0, 1'b0, 6'd44, 4'd5,  6'd44, S_MRD);
    add(LW, 1'b0, 1'b0, 6'd44, 4'd5,  6'd44, S_MRD);
    add(LW, 1'b0, 1'b1, 6'd44, 4'd5,  6'd44, S_MRD);
    add(LW, 1'b0, 1'b1, 6'd44, 4'd10, 6'd44, S_WBM);
    // halt
    add(HL, 1'b0, 1'b1, 6'd44, 4'd0,  6'd45, S_FRDY);
    add(HL, 1'b0, 1'b1, 6'd45, 4'd1,  6'd45, S_NONE);
    add(HL, 1'b0, 1'b1, 6'd45, 4'd11, 6'd45, S_HLT);

    // Reset with a nonzero PC: everything quiet, PC reloaded to 0.
    rst = 1'b1; opcode = RT; zero = 1'b0; imm = 6'd0; jtarget = 6'd0;
    pc_addr = 6'd17; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 0, state, 4'd0);
    chk("rst_next_addr", 0, next_addr, 6'd0);
    chk("rst_strobes", 0, sb, S_NONE);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      opcode = vecs[i].op; zero = vecs[i].zr; mem_ready = vecs[i].rdy;
      pc_addr = vecs[i].pc; imm = vecs[i].im; jtarget = vecs[i].jt;
      #1;
      chk("vec_state", i, state, vecs[i].st);
      chk("vec_next_addr", i, next_addr, vecs[i].na);
      chk("vec_strobes", i, sb, vecs[i].sb);
      @(negedge clk);
    end

    // HALT holds for 20 cycles regardless of mem_ready or opcode.
    for (int c = 0; c < 20; c++) begin
      mem_ready = 1'($urandom_range(1, 0));
      opcode = (c % 2 == 0) ? RT : JJ;
      #1;
      chk("halt_state", c, state, 4'd11);
      chk("halt_pc_hold", c, next_addr, 6'd45);
      chk("halt_strobes", c, sb, S_HLT);
      @(negedge clk);
    end

    // Only rst leaves HALT, and it takes effect without a clock edge.
    rst = 1'b1;
    #1;
    chk("halt_rst_state", 0, state, 4'd0);
    chk("halt_rst_strobes", 0, sb, S_NONE);
    chk("halt_rst_next_addr", 0, next_addr, 6'd0);

    // Reset during a stalled fetch drops mem_read immediately.
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0; pc_addr = 6'd0; opcode = RT;
    #1;
    chk("stall_mem_read", 0, sb, S_MRD);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_strobes", 0, sb, S_NONE);
    chk("abort_next_addr", 0, next_addr, 6'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Main control state machine for the multi-cycle MIPS core. It sequences fetch, decode, execute, memory and write-back phases and issues the datapath strobes for each phase. It also computes the program counter's next address. The `PC` register loads `next_addr` on every rising clock edge, so this block presents the current address back unchanged whenever no update is due. It sits between the instruction register, ALU flags, memory and the `PC` register.

## Interface
- `ADDR_W`, 6, width of the word address: PC, branch offset and jump target.
- `clk` input 1: core clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `opcode` input 6: IR[31:26], stable from the cycle after `ir_write`.
- `zero` input 1: ALU zero flag, valid in EXEC_BR.
- `imm` input ADDR_W: branch word offset (two's complement), from the IR.
- `jtarget` input ADDR_W: jump target word address, from the IR.
- `pc_addr` input ADDR_W: current PC value (`PC.addr`).
- `mem_ready` input 1: memory completes the current access this cycle.
- `next_addr` output ADDR_W: drives `PC.next_addr`.
- `pc_write` output 1: high in any cycle where `next_addr` differs in source from `pc_addr`.
- `ir_write` output 1: loads the IR.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `reg_write` output 1: register file write.
- `reg_dst` output 1: 1 selects rd, 0 selects rt.
- `mem_to_reg` output 1: 1 selects memory data for write-back.
- `alu_src` output 1: 1 selects the immediate.
- `alu_op` output 2: 00 add, 01 subtract, 10 funct-decoded.
- `halted` output 1: core stopped.
- `state` output 4: current state encoding, for debug.

## Operation
State encodings:
- FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, EXEC_BR=7, WB_R=8, WB_I=9, WB_MEM=10, HALT=11. Codes 12–15 are illegal and go to FETCH on the next edge.

Opcode decode in DECODE:
- 000000 (R-type) goes to EXEC_R.
- 001000 (addi) goes to EXEC_I.
- 100011 (lw) and 101011 (sw) go to ADDR.
- 000100 (beq) goes to EXEC_BR.
- 000010 (j) goes to FETCH with `next_addr=jtarget` and `pc_write=1`.
- 111111 (halt) goes to HALT.
- Any other opcode goes to FETCH (treated as a NOP).

Per-state behaviour:
- FETCH: `mem_read=1`. While `mem_ready=0` the state holds. When `mem_ready=1`: `ir_write=1`, `next_addr=pc_addr+1`, `pc_write=1`, and the state goes to DECODE.
- EXEC_R: `alu_op=10`, go to WB_R.
- WB_R: `reg_write=1`, `reg_dst=1`, go to FETCH.
- EXEC_I: `alu_src=1`, `alu_op=00`, go to WB_I.
- WB_I: `reg_write=1`, `reg_dst=0`, go to FETCH.
- ADDR: `alu_src=1`, `alu_op=00`. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read=1`. Hold until `mem_ready`, then go to WB_MEM.
- MEM_WR: `mem_write=1`. Hold until `mem_ready`, then go to FETCH.
- WB_MEM: `reg_write=1`, `mem_to_reg=1`, `reg_dst=0`, go to FETCH.
- EXEC_BR: `alu_op=01`. If `zero=1`: `next_addr=pc_addr+imm` and `pc_write=1`. Go to FETCH either way.
- HALT: `halted=1`, all strobes 0. The state holds until `rst`.

Next-address rules:
- `pc_addr` already holds PC+1 by the time a branch executes.
- All address adds are modulo 2^ADDR_W; wrap is silent. Examples: 63+1=0, 5+(-6)=63.
- When `pc_write=0`, `next_addr=pc_addr`.

## Timing
- Outputs are Moore-decoded from `state`. The exceptions are the `mem_ready`-qualified strobes in FETCH (`ir_write`, `pc_write`, `next_addr`) and the `zero`-qualified `pc_write`/`next_addr` in EXEC_BR.
- Reset: while `rst=1`, `state=FETCH` and `next_addr=0`, so the PC is reloaded to 0. All strobes are 0 and `halted=0`.
  - Release is asynchronous-assert, synchronous-effect: the first FETCH is the first edge after `rst` falls.
  - Reset mid-access drops any `mem_read`/`mem_write` immediately.
- Latency with zero-wait memory (`mem_ready` tied to 1):
  - j: 2 cycles.
  - beq: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - NOP: 2 cycles.
- Each memory wait cycle adds exactly one cycle.
- Per instruction: exactly one PC increment (in FETCH) plus at most one redirect (j or taken beq).
- `mem_ready` is ignored outside FETCH, MEM_RD and MEM_WR.

## Test plan
- Reset and fetch: assert `rst` with `pc_addr=17`. Require `next_addr=0`, `state=0` and all strobes 0. Release with `mem_ready=1`: after one edge `state=1` and the PC has taken 1.
- R-type sequence: zero-wait, opcode 000000. Require states 0,1,2,8 over 4 cycles. `reg_write=1` and `reg_dst=1` only in WB_R. PC advances by exactly 1.
- lw with wait: opcode 100011, `mem_ready` low for 2 cycles in MEM_RD. Require 7 cycles total, `mem_read` held throughout MEM_RD, and `mem_to_reg=1` in WB_MEM.
- beq:
  - Taken case: `pc_addr=5`, `imm=6'b111010` (-6), `zero=1`. Require `next_addr=63` and `pc_write=1` in EXEC_BR.
  - Not-taken case: `zero=0`. Require `next_addr=pc_addr` and `pc_write=0`.
- j and wrap:
  - Jump: `jtarget=42`. Require `next_addr=42` in DECODE, then FETCH.
  - Wrap: separately, `pc_addr=63` in FETCH gives `next_addr=0`.
- Halt and illegal opcode:
  - Opcode 111111 must reach HALT, hold `halted=1` for 20 cycles with PC constant, and leave only on `rst`.
  - Opcode 010101 must return to FETCH after DECODE with no strobes.
